register_file: RTL and testbench
================================

REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 Parameter DATA_WIDTH, default 64, SHALL set the width of each register and of the data ports.
REQ-003 Parameter NUM_REGS, default 32, SHALL set the register count; ADDR_WIDTH = clog2(NUM_REGS), default 5.
REQ-004 Port: clk  input  1  rising-edge clock for all writes.
REQ-005 Port: rst_n  input  1  asynchronous active-low reset.
REQ-006 Port: readRegister1  input  ADDR_WIDTH  read port 1 address.
REQ-007 Port: readRegister2  input  ADDR_WIDTH  read port 2 address.
REQ-008 Port: writeRegister  input  ADDR_WIDTH  write port address.
REQ-009 Port: writeData  input  DATA_WIDTH  write data.
REQ-010 Port: regWrite  input  1  write enable, active high.
REQ-011 Port: readData1  output  DATA_WIDTH  contents at readRegister1.
REQ-012 Port: readData2  output  DATA_WIDTH  contents at readRegister2.

Function
REQ-013 Reads SHALL be combinational: readDataN SHALL reflect the current contents at readRegisterN with zero cycle latency, with no clock needed.
REQ-014 On a rising clk edge with rst_n high and regWrite=1, register[writeRegister] SHALL take writeData.
REQ-015 With regWrite=0, no register SHALL change.
REQ-016 Register 0 SHALL be hardwired zero: writes to address 0 SHALL be ignored, and reads of address 0 SHALL return 0 on both ports.
REQ-017 Both read ports SHALL be independent; equal addresses on both ports SHALL return identical data.
REQ-018 Writing one address SHALL NOT disturb any other register.
REQ-019 Addresses at or above NUM_REGS, possible only when NUM_REGS is not a power of two, SHALL read 0, and writes to them SHALL be ignored.
REQ-020 A write and a read to the same nonzero address in the same cycle SHALL follow REQ-027/REQ-028.
REQ-021 X or Z on regWrite SHALL NOT be treated as a write; the design SHALL treat only 1'b1 as enable.

Reset
REQ-022 Asserting rst_n low SHALL immediately clear all registers to 0, independent of clk.
REQ-023 While rst_n is low, both read outputs SHALL be 0 and writes SHALL be blocked.
REQ-024 A write coinciding with the clk edge on which rst_n is low SHALL be discarded.
REQ-025 After rst_n deasserts, the first rising clk edge SHALL accept a write.
REQ-026 Reset asserted in the middle of a write sequence SHALL leave all registers at 0, and no partial state SHALL remain.

Configuration
REQ-027 With macro REGFILE_BYPASS_EN defined, if regWrite=1, writeRegister is nonzero and equal to readRegisterN, and rst_n is high, then readDataN SHALL combinationally return writeData in that cycle (write-to-read forwarding).
REQ-028 Without REGFILE_BYPASS_EN, readDataN SHALL return the old stored value until the rising edge commits the write.

Verification
REQ-029 Scenario: rst_n=0, r1=0, r2=0, regWrite=0 for 210 time units -> readData1=readData2=0 throughout.
REQ-030 Scenario: write 0xDEADBEEF_CAFEF00D to reg 5, then read r1=5 and r2=5 -> both read 0xDEADBEEF_CAFEF00D the cycle after the edge.
REQ-031 Scenario: write 0xFFFF_FFFF_FFFF_FFFF to reg 0 -> readData1 with r1=0 stays 0.
REQ-032 Scenario: write i*0x0101 to regs 1..31, then read all regs -> each reg i returns i*0x0101 and reg 0 returns 0.
REQ-033 Scenario: regWrite=1, w=7, wd=0x1234, r1=7 before the edge -> readData1=0x1234 with REGFILE_BYPASS_EN defined, and the prior value (0) without it.
REQ-034 Scenario: fill regs 1..31 with nonzero values, pulse rst_n low mid-cycle -> all reads return 0 immediately, before any clk edge.

Source files
------------

// File: rtl/register_file.sv
// Two-read / one-write register file with hardwired-zero register 0 and async active-low reset.
// Optional write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module register_file #(
    parameter int  DATA_WIDTH = 64,
    parameter int  NUM_REGS   = 32,
    localparam int ADDR_WIDTH = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] readRegister1,
    input  logic [ADDR_WIDTH-1:0] readRegister2,
    input  logic [ADDR_WIDTH-1:0] writeRegister,
    input  logic [DATA_WIDTH-1:0] writeData,
    input  logic                  regWrite,
    output logic [DATA_WIDTH-1:0] readData1,
    output logic [DATA_WIDTH-1:0] readData2
);

    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

    logic w_rd1_in_range;
    logic w_rd2_in_range;
    logic w_wr_in_range;
    logic w_wr_en;
    logic [DATA_WIDTH-1:0] w_stored1;
    logic [DATA_WIDTH-1:0] w_stored2;

    // Out-of-range addresses only exist when NUM_REGS is not a power of two.
    generate
        if (NUM_REGS == (1 << ADDR_WIDTH)) begin : g_full_range
            assign w_rd1_in_range = 1'b1;
            assign w_rd2_in_range = 1'b1;
            assign w_wr_in_range  = 1'b1;
        end else begin : g_partial_range
            localparam logic [ADDR_WIDTH:0] LP_NUM_REGS = NUM_REGS[ADDR_WIDTH:0];
            assign w_rd1_in_range = ({1'b0, readRegister1} < LP_NUM_REGS);
            assign w_rd2_in_range = ({1'b0, readRegister2} < LP_NUM_REGS);
            assign w_wr_in_range  = ({1'b0, writeRegister} < LP_NUM_REGS);
        end
    endgenerate

    // An X on regWrite evaluates false in the if below, so only a clean 1 writes.
    assign w_wr_en = regWrite && (writeRegister != '0) && w_wr_in_range;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[writeRegister] <= writeData;
        end
    end

    always_comb begin
        w_stored1 = '0;
        w_stored2 = '0;
        if (rst_n && w_rd1_in_range && (readRegister1 != '0)) begin
            w_stored1 = r_regs[readRegister1];
        end
        if (rst_n && w_rd2_in_range && (readRegister2 != '0)) begin
            w_stored2 = r_regs[readRegister2];
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic w_fwd1;
    logic w_fwd2;

    assign w_fwd1 = rst_n && w_wr_en && (writeRegister == readRegister1);
    assign w_fwd2 = rst_n && w_wr_en && (writeRegister == readRegister2);

    assign readData1 = w_fwd1 ? writeData : w_stored1;
    assign readData2 = w_fwd2 ? writeData : w_stored2;
`else
    assign readData1 = w_stored1;
    assign readData2 = w_stored2;
`endif

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file (default 64-bit x 32 configuration).
// Expected values are hand-computed constants; bypass expectations follow REGFILE_BYPASS_EN.
module tb_register_file;

    logic        clk;
    logic        rst_n;
    logic [4:0]  readRegister1;
    logic [4:0]  readRegister2;
    logic [4:0]  writeRegister;
    logic [63:0] writeData;
    logic        regWrite;
    logic [63:0] readData1;
    logic [63:0] readData2;

    int checks;
    int errors;

    register_file dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .readRegister1 (readRegister1),
        .readRegister2 (readRegister2),
        .writeRegister (writeRegister),
        .writeData     (writeData),
        .regWrite      (regWrite),
        .readData1     (readData1),
        .readData2     (readData2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_write(input logic [4:0] a, input logic [63:0] d);
        @(negedge clk);
        writeRegister = a;
        writeData     = d;
        regWrite      = 1'b1;
        @(negedge clk);
        regWrite      = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        readRegister1 = 5'd0;
        readRegister2 = 5'd0;
        regWrite = 1'b0;
        writeRegister = 5'd0;
        writeData = 64'd0;
        for (int t = 0; t < 21; t++) begin
            #10;
            checks++;
            if (readData1 !== 64'd0 || readData2 !== 64'd0) begin
                errors++;
                $display("FAIL reset_hold t=%0d: rd1=%h rd2=%h expected 0", t, readData1, readData2);
            end
        end
        // writes attempted while in reset must be discarded
        @(negedge clk);
        writeRegister = 5'd3;
        writeData = 64'h1111_2222_3333_4444;
        regWrite = 1'b1;
        readRegister1 = 5'd3;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (readData1 !== 64'd0) begin
            errors++;
            $display("FAIL reset_write_block: rd1=%h expected 0", readData1);
        end
        regWrite = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (readData1 !== 64'd0) begin
            errors++;
            $display("FAIL reset_release_r3: rd1=%h expected 0", readData1);
        end
    endtask

    task automatic test_bypass;
        // reg 7 holds 0 after reset; present a write to it with r1=7 before the edge
        @(negedge clk);
        writeRegister = 5'd7;
        writeData = 64'h1234;
        regWrite = 1'b1;
        readRegister1 = 5'd7;
        readRegister2 = 5'd7;
        #1;
        checks++;
`ifdef REGFILE_BYPASS_EN
        if (readData1 !== 64'h1234 || readData2 !== 64'h1234) begin
            errors++;
            $display("FAIL bypass_fwd: rd1=%h rd2=%h expected 1234", readData1, readData2);
        end
`else
        if (readData1 !== 64'd0 || readData2 !== 64'd0) begin
            errors++;
            $display("FAIL bypass_old: rd1=%h rd2=%h expected 0", readData1, readData2);
        end
`endif
        @(negedge clk);
        regWrite = 1'b0;
        #1;
        checks++;
        if (readData1 !== 64'h1234) begin
            errors++;
            $display("FAIL bypass_commit: rd1=%h expected 1234", readData1);
        end
    endtask

    task automatic test_post_reset_write;
        // first edge after release accepts a write
        rst_n = 1'b0;
        #3;
        @(negedge clk);
        rst_n = 1'b1;
        writeRegister = 5'd3;
        writeData = 64'h0A0B_0C0D_0E0F_1011;
        regWrite = 1'b1;
        readRegister1 = 5'd3;
        @(negedge clk);
        regWrite = 1'b0;
        #1;
        checks++;
        if (readData1 !== 64'h0A0B_0C0D_0E0F_1011) begin
            errors++;
            $display("FAIL first_write_after_reset: rd1=%h expected 0a0b0c0d0e0f1011", readData1);
        end
    endtask

    task automatic test_write_read;
        do_write(5'd5, 64'hDEAD_BEEF_CAFE_F00D);
        readRegister1 = 5'd5;
        readRegister2 = 5'd5;
        #1;
        checks++;
        if (readData1 !== 64'hDEAD_BEEF_CAFE_F00D || readData2 !== 64'hDEAD_BEEF_CAFE_F00D) begin
            errors++;
            $display("FAIL write_read_r5: rd1=%h rd2=%h expected deadbeefcafef00d", readData1, readData2);
        end
    endtask

    task automatic test_reg0;
        do_write(5'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        readRegister1 = 5'd0;
        readRegister2 = 5'd0;
        #1;
        checks++;
        if (readData1 !== 64'd0 || readData2 !== 64'd0) begin
            errors++;
            $display("FAIL reg0_zero: rd1=%h rd2=%h expected 0", readData1, readData2);
        end
    endtask

    task automatic test_fill;
        for (int i = 1; i < 32; i++) begin
            do_write(5'(i), 64'(i) * 64'h0101);
        end
        for (int i = 0; i < 32; i++) begin
            logic [63:0] exp1;
            logic [63:0] exp2;
            readRegister1 = 5'(i);
            readRegister2 = 5'(31 - i);
            exp1 = 64'(i) * 64'h0101;
            exp2 = 64'(31 - i) * 64'h0101;
            #1;
            checks++;
            if (readData1 !== exp1 || readData2 !== exp2) begin
                errors++;
                $display("FAIL fill_read i=%0d: rd1=%h rd2=%h expected %h %h", i, readData1, readData2, exp1, exp2);
            end
        end
    endtask

    task automatic test_no_write;
        // regWrite low: data on the bus must not land
        @(negedge clk);
        writeRegister = 5'd9;
        writeData = 64'h5555_AAAA_5555_AAAA;
        regWrite = 1'b0;
        @(negedge clk);
        @(negedge clk);
        readRegister1 = 5'd9;
        readRegister2 = 5'd10;
        #1;
        checks++;
        if (readData1 !== 64'h0909 || readData2 !== 64'h0A0A) begin
            errors++;
            $display("FAIL no_write: rd1=%h rd2=%h expected 0909 0a0a", readData1, readData2);
        end
    endtask

    task automatic test_isolation;
        // overwriting one register leaves its neighbours intact
        do_write(5'd12, 64'h0123_4567_89AB_CDEF);
        readRegister1 = 5'd12;
        readRegister2 = 5'd11;
        #1;
        checks++;
        if (readData1 !== 64'h0123_4567_89AB_CDEF || readData2 !== 64'h0B0B) begin
            errors++;
            $display("FAIL isolation_a: rd1=%h rd2=%h expected 0123456789abcdef 0b0b", readData1, readData2);
        end
        readRegister2 = 5'd13;
        #1;
        checks++;
        if (readData2 !== 64'h0D0D) begin
            errors++;
            $display("FAIL isolation_b: rd2=%h expected 0d0d", readData2);
        end
    endtask

    task automatic test_reset_mid;
        // assert reset between edges; outputs must drop before any clock edge
        @(negedge clk);
        writeRegister = 5'd20;
        writeData = 64'hFEED_FACE_0000_0001;
        regWrite = 1'b1;
        readRegister1 = 5'd31;
        readRegister2 = 5'd1;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (readData1 !== 64'd0 || readData2 !== 64'd0) begin
            errors++;
            $display("FAIL reset_mid_immediate: rd1=%h rd2=%h expected 0", readData1, readData2);
        end
        @(negedge clk);
        regWrite = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            readRegister1 = 5'(i);
            #1;
            checks++;
            if (readData1 !== 64'd0) begin
                errors++;
                $display("FAIL reset_mid_cleared i=%0d: rd1=%h expected 0", i, readData1);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset;
        test_bypass;
        test_post_reset_write;
        test_write_read;
        test_reg0;
        test_fill;
        test_no_write;
        test_isolation;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
